// File: rtl/muldiv_pkg.sv
// muldiv shared types: RISC-V M funct3 encodings and FSM states.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_func_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv request/result bundle.
interface muldiv_if #(
    parameter int DWIDTH = 32
);
    logic              Start;
    logic [DWIDTH-1:0] A;
    logic [DWIDTH-1:0] B;
    logic [2:0]        MDFunc;
    logic              Busy;
    logic              Done;
    logic [DWIDTH-1:0] MDOut;

    modport master (
        output Start, A, B, MDFunc,
        input  Busy, Done, MDOut
    );

    modport slave (
        input  Start, A, B, MDFunc,
        output Busy, Done, MDOut
    );
endinterface

// File: rtl/muldiv_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
module muldiv_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dvd,
    input  logic [W-1:0] dvs,
    output logic         last,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CMAX = CW'(W - 1);

    logic [W-1:0]  q_r;
    logic [W-1:0]  r_r;
    logic [W-1:0]  d_r;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [W:0]    shifted;
    logic          ge;
    logic [W-1:0]  r_nx;

    always_comb begin
        shifted = {r_r, q_r[W-1]};
        ge      = shifted >= {1'b0, d_r};
        // a fit leaves less than the divisor, so W bits suffice
        r_nx    = ge ? shifted[W-1:0] - d_r : shifted[W-1:0];
    end

    assign last = busy && (cnt == CMAX);
    assign quo  = q_r;
    assign rem  = r_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r  <= '0;
            r_r  <= '0;
            d_r  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            q_r  <= dvd;
            r_r  <= '0;
            d_r  <= dvs;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            q_r  <= {q_r[W-2:0], ge};
            r_r  <= r_nx;
            cnt  <= cnt + 1'b1;
            busy <= !last;
        end
    end

endmodule

// File: rtl/muldiv.sv
// RISC-V M-extension unit: single-cycle multiply, 32-step divide.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic     clock,
    input  logic     nReset,
    muldiv_if.slave  bus
);
    localparam int MSB = DWIDTH - 1;
    localparam logic [DWIDTH-1:0] MINV = {1'b1, {MSB{1'b0}}};

    state_t            state;
    state_t            state_nx;
    logic [DWIDTH-1:0] a_q;
    logic [DWIDTH-1:0] b_q;
    md_func_t          fn_q;
    logic [DWIDTH-1:0] out_q;
    logic              done_q;

    logic              sgn_in;
    logic              spec_in;
    logic              div_start;
    logic [DWIDTH-1:0] abs_a;
    logic [DWIDTH-1:0] abs_b;

    logic              div_last;
    logic [DWIDTH-1:0] div_quo;
    logic [DWIDTH-1:0] div_rem;

    logic                   ext_a;
    logic                   ext_b;
    logic signed [DWIDTH:0] ma;
    logic signed [DWIDTH:0] mb;
    logic [2*DWIDTH-1:0]    prod;
    logic [DWIDTH-1:0]      mul_res;

    logic              sgn_q;
    logic              neg_a;
    logic              neg_b;
    logic              zero_b;
    logic              ovf;
    logic [DWIDTH-1:0] q_fix;
    logic [DWIDTH-1:0] r_fix;
    logic [DWIDTH-1:0] fix_res;

    // request side: special cases bypass the iterative core
    always_comb begin
        sgn_in  = !bus.MDFunc[0];
        spec_in = (bus.B == '0)
               || (sgn_in && bus.A == MINV && bus.B == '1);
        abs_a   = (sgn_in && bus.A[MSB]) ? -bus.A : bus.A;
        abs_b   = (sgn_in && bus.B[MSB]) ? -bus.B : bus.B;
        div_start = bus.Start && (state == S_IDLE)
                 && bus.MDFunc[2] && !spec_in;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (bus.Start) begin
                    if (!bus.MDFunc[2]) state_nx = S_MUL;
                    else if (spec_in)   state_nx = S_FIX;
                    else                state_nx = S_DIV;
                end
            end
            S_MUL: state_nx = S_IDLE;
            S_DIV: if (div_last) state_nx = S_FIX;
            S_FIX: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ext_a   = (fn_q != MD_MULHU) && a_q[MSB];
        ext_b   = (fn_q == MD_MUL || fn_q == MD_MULH) && b_q[MSB];
        ma      = {ext_a, a_q};
        mb      = {ext_b, b_q};
        prod    = (2*DWIDTH)'(ma) * (2*DWIDTH)'(mb);
        mul_res = (fn_q == MD_MUL) ? prod[DWIDTH-1:0]
                                   : prod[2*DWIDTH-1:DWIDTH];
    end

    always_comb begin
        sgn_q  = !fn_q[0];
        neg_a  = sgn_q && a_q[MSB];
        neg_b  = sgn_q && b_q[MSB];
        zero_b = (b_q == '0);
        ovf    = sgn_q && a_q == MINV && b_q == '1;
        q_fix  = (neg_a ^ neg_b) ? -div_quo : div_quo;
        r_fix  = neg_a ? -div_rem : div_rem;
        fix_res = fn_q[1] ? r_fix : q_fix;
        unique case (1'b1)
            zero_b:  fix_res = fn_q[1] ? a_q : '1;
            ovf:     fix_res = fn_q[1] ? '0 : a_q;
            default: fix_res = fn_q[1] ? r_fix : q_fix;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            fn_q   <= MD_MUL;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            if (bus.Start && state == S_IDLE) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                fn_q <= md_func_t'(bus.MDFunc);
            end
            if (state == S_MUL) begin
                out_q  <= mul_res;
                done_q <= 1'b1;
            end
            if (state == S_FIX) begin
                out_q  <= fix_res;
                done_q <= 1'b1;
            end
        end
    end

    muldiv_divider #(
        .W (DWIDTH)
    ) u_div (
        .clk   (clock),
        .rst_n (nReset),
        .start (div_start),
        .dvd   (abs_a),
        .dvs   (abs_b),
        .last  (div_last),
        .quo   (div_quo),
        .rem   (div_rem)
    );

    assign bus.Busy  = (state != S_IDLE);
    assign bus.Done  = done_q;
    assign bus.MDOut = out_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed vector bench for muldiv: results, latency, corner sequences.
module tb_muldiv;

    logic clock;
    logic nReset;

    muldiv_if #(.DWIDTH(32)) bus ();

    muldiv #(
        .DWIDTH (32)
    ) u_dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vt[$];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // issue one op, scramble inputs afterwards, time and check the result
    task automatic do_op(input vec_t v);
        int n;
        bit seen;
        @(negedge clock);
        bus.Start  = 1'b1;
        bus.A      = v.a;
        bus.B      = v.b;
        bus.MDFunc = v.f;
        @(posedge clock);
        #1;
        bus.Start  = 1'b0;
        bus.A      = $urandom;
        bus.B      = $urandom;
        bus.MDFunc = 3'($urandom);
        chk({v.name, " busy"}, 32'(bus.Busy), 32'd1);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.Done) seen = 1'b1;
        end
        chk({v.name, " latency"}, seen ? n : -1, v.lat);
        chk({v.name, " result"}, bus.MDOut, v.exp);
        @(posedge clock);
        #1;
        chk({v.name, " done pulse"}, 32'(bus.Done), 32'd0);
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [31:0] exp,
                       input int lat, input string name);
        vec_t v;
        v.a = a; v.b = b; v.f = f; v.exp = exp; v.lat = lat; v.name = name;
        vt.push_back(v);
    endtask

    initial begin
        int dn;
        checks = 0;
        errors = 0;
        bus.Start  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.MDFunc = '0;

        add(32'd120, 32'hFFFFFFE8, 3'b000, 32'hFFFFF4C0, 1, "mul");
        add(32'd120, 32'hFFFFFFE8, 3'b001, 32'hFFFFFFFF, 1, "mulh");
        add(32'd120, 32'hFFFFFFE8, 3'b010, 32'h00000077, 1, "mulhsu");
        add(32'd120, 32'hFFFFFFE8, 3'b011, 32'h00000077, 1, "mulhu");
        add(32'd120, 32'hFFFFFFE8, 3'b100, 32'hFFFFFFFB, 33, "div");
        add(32'd120, 32'hFFFFFFE8, 3'b101, 32'h00000000, 33, "divu");
        add(32'hFFFFFFE8, 32'd120, 3'b101, 32'h02222221, 33, "divu2");
        add(32'hFFFFFFE8, 32'd120, 3'b110, 32'hFFFFFFE8, 33, "rem");
        add(32'hFFFFFFE8, 32'd120, 3'b111, 32'h00000070, 33, "remu");
        add(32'h12345678, 32'h0, 3'b100, 32'hFFFFFFFF, 1, "div0");
        add(32'h12345678, 32'h0, 3'b101, 32'hFFFFFFFF, 1, "divu0");
        add(32'h12345678, 32'h0, 3'b110, 32'h12345678, 1, "rem0");
        add(32'h12345678, 32'h0, 3'b111, 32'h12345678, 1, "remu0");
        add(32'h80000000, 32'hFFFFFFFF, 3'b100, 32'h80000000, 1, "div_ovf");
        add(32'h80000000, 32'hFFFFFFFF, 3'b110, 32'h00000000, 1, "rem_ovf");
        add(32'h80000000, 32'hFFFFFFFF, 3'b001, 32'h00000000, 1, "mulh_min");
        add(32'h80000000, 32'hFFFFFFFF, 3'b011, 32'h7FFFFFFF, 1, "mulhu_min");
        add(32'hFFFFFFF9, 32'd2, 3'b100, 32'hFFFFFFFD, 33, "div_neg");
        add(32'hFFFFFFF9, 32'd2, 3'b110, 32'hFFFFFFFF, 33, "rem_neg");
        add(32'd7, 32'hFFFFFFFE, 3'b110, 32'h00000001, 33, "rem_negb");
        add(32'd100, 32'd7, 3'b101, 32'h0000000E, 33, "divu_small");
        add(32'h0000FFFF, 32'h0000FFFF, 3'b000, 32'hFFFE0001, 1, "mul_ffff");

        nReset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", 32'(bus.Busy), 32'd0);
        chk("reset done", 32'(bus.Done), 32'd0);
        chk("reset mdout", bus.MDOut, 32'd0);
        @(negedge clock);
        nReset = 1'b1;

        foreach (vt[i]) do_op(vt[i]);

        // restart while busy: second request and its operands are dropped
        @(negedge clock);
        bus.Start = 1'b1; bus.A = 32'd1000; bus.B = 32'd7; bus.MDFunc = 3'b100;
        @(posedge clock);
        #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        bus.Start = 1'b1; bus.A = 32'd3; bus.B = 32'd5; bus.MDFunc = 3'b000;
        @(posedge clock);
        #1;
        bus.Start = 1'b0;
        dn = 0;
        for (int c = 11; c <= 40 && dn == 0; c++) begin
            @(posedge clock);
            #1;
            if (bus.Done) dn = c;
        end
        chk("busy restart latency", dn, 33);
        chk("busy restart result", bus.MDOut, 32'd142);

        // same, then reset mid-divide aborts everything
        @(negedge clock);
        bus.Start = 1'b1; bus.A = 32'd1000; bus.B = 32'd7; bus.MDFunc = 3'b100;
        @(posedge clock);
        #1;
        bus.Start = 1'b0;
        dn = 0;
        for (int c = 1; c < 20; c++) begin
            if (c == 10) begin
                @(negedge clock);
                bus.Start = 1'b1; bus.A = 32'd3; bus.B = 32'd5;
                bus.MDFunc = 3'b000;
                @(posedge clock);
                #1;
                bus.Start = 1'b0;
            end else begin
                @(posedge clock);
                #1;
            end
            if (bus.Done) dn++;
        end
        chk("abort early done", dn, 0);
        chk("abort busy before reset", 32'(bus.Busy), 32'd1);
        @(negedge clock);
        nReset = 1'b0;
        #1;
        chk("abort busy", 32'(bus.Busy), 32'd0);
        chk("abort done", 32'(bus.Done), 32'd0);
        chk("abort mdout", bus.MDOut, 32'd0);
        @(negedge clock);
        nReset = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.Done) dn++;
        end
        chk("abort no done", dn, 0);
        chk("abort mdout held", bus.MDOut, 32'd0);

        do_op(vt[0]);

        // Start held four cycles: accepted on edges 0 and 2 only
        @(negedge clock);
        bus.Start = 1'b1; bus.A = 32'd3; bus.B = 32'd5; bus.MDFunc = 3'b000;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        bus.A = 32'd7; bus.B = 32'd11;
        chk("b2b done1", 32'(bus.Done), 32'd1);
        chk("b2b result1", bus.MDOut, 32'd15);
        @(posedge clock);
        #1;
        chk("b2b gap", 32'(bus.Done), 32'd0);
        @(posedge clock);
        #1;
        bus.Start = 1'b0;
        chk("b2b done2", 32'(bus.Done), 32'd1);
        chk("b2b result2", bus.MDOut, 32'd77);
        @(posedge clock);
        #1;
        chk("b2b end done", 32'(bus.Done), 32'd0);
        chk("b2b end busy", 32'(bus.Busy), 32'd0);
        @(posedge clock);
        #1;
        chk("b2b no third", 32'(bus.Done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameter DWIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  one-cycle request; samples A, B, MDFunc when high and unit idle.
REQ-005 A  input  DWIDTH  operand rs1, signed (two's complement).
REQ-006 B  input  DWIDTH  operand rs2, signed (two's complement).
REQ-007 MDFunc  input  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Busy  output  1  high while an operation is in progress.
REQ-009 Done  output  1  one-cycle pulse when MDOut updates with a new result.
REQ-010 MDOut  output  DWIDTH  registered result; holds its value until the next Done.

Function
REQ-011 MUL SHALL return low DWIDTH bits of A*B.
REQ-012 MULH SHALL return high DWIDTH bits of signed(A)*signed(B), 2*DWIDTH-bit product.
REQ-013 MULHSU SHALL return high bits of signed(A)*unsigned(B).
REQ-014 MULHU SHALL return high bits of unsigned(A)*unsigned(B).
REQ-015 Multiply ops SHALL complete with Done one cycle after the Start cycle; Busy high during that cycle.
REQ-016 DIV/REM SHALL use signed operands, quotient truncated toward zero; remainder takes the sign of the dividend.
REQ-017 DIVU/REMU SHALL treat operands as unsigned.
REQ-018 Divide ops SHALL use an iterative restoring divider on magnitudes: 32 iteration cycles plus 1 sign-fix cycle; Done on cycle 33 after Start.
REQ-019 Divide by zero SHALL give quotient all-ones (DIV and DIVU) and remainder = A (REM and REMU), with Done one cycle after Start.
REQ-020 Signed overflow (A = -2^31, B = -1) SHALL give DIV = -2^31, REM = 0, with Done one cycle after Start.
REQ-021 Start while Busy SHALL be ignored; the operands of the in-flight operation SHALL be unaffected.
REQ-022 Start asserted in the same cycle as Done SHALL be accepted; the new operation begins.
REQ-023 Operands and MDFunc SHALL be latched at Start; later input changes SHALL NOT affect the result.
REQ-024 FSM states: IDLE, MUL, DIV, FIX.
  - IDLE->MUL on Start with MDFunc[2]=0.
  - IDLE->DIV on Start with a divide op; IDLE->FIX on a divide special case.
  - DIV->FIX after 32 iterations.
  - MUL->IDLE and FIX->IDLE, each asserting Done.

Reset
REQ-025 nReset low SHALL asynchronously force: state IDLE, Busy 0, Done 0, MDOut 0, all internal registers 0.
REQ-026 Reset mid-operation SHALL abort it; no Done SHALL be produced for the aborted operation.
REQ-027 The first Start after reset deassertion SHALL be accepted.

Structure
REQ-028 A shared package SHALL hold the MDFunc encodings (enum md_func_t) and the FSM state enum.
REQ-029 The divider datapath SHALL be one sub-module, muldiv_divider (iterative unsigned 32/32 core with start/done).
REQ-030 The multiplier SHALL be a single 33x33 signed multiply on sign- or zero-extended operands, inline in the top level.

Verification
REQ-031 A=120, B=-24, each of MDFunc 000..101 -> MDOut 0xFFFFF4C0, 0xFFFFFFFF, 0x00000077, 0x00000077, 0xFFFFFFFB, 0x00000000 respectively.
REQ-032 A=-24, B=120:
  - DIVU -> 0x02222221.
  - REM -> 0xFFFFFFE8.
  - REMU -> 0x00000070.
  - Each with Done exactly 33 cycles after Start.
REQ-033 B=0, A=0x12345678 -> DIV/DIVU 0xFFFFFFFF, REM/REMU 0x12345678, Done 1 cycle after Start.
REQ-034 A=0x80000000, B=0xFFFFFFFF -> DIV 0x80000000, REM 0, MULH 0x00000000, MULHU 0x7FFFFFFF.
REQ-035 Start DIV, re-pulse Start with a different MDFunc at cycle 10, then nReset low at cycle 20:
  - The cycle-10 Start is ignored.
  - After reset: Busy 0, Done never pulses, MDOut 0.
REQ-036 Back-to-back MUL requests with Start held high for 4 cycles -> 2 results; Done on cycles 1 and 3 (Start accepted on the Done cycle, REQ-022).
